// File: rtl/multplus_sequencer_if.sv
// rtl/multplus_sequencer_if.sv - MULTPLUS request/response bundle between decode and the sequencer
//
// Purpose: groups the MULTPLUS request operands and the response/status
//          signals so decode and the sequencer connect through one port.
// Ports (signals):
//   start            request from decode, sampled only while the sequencer is idle
//   op_a, op_b, op_c multiplicand, multiplier, addend (WIDTH bits each)
//   stall            hold PC / register-file writes (combinational)
//   busy             registered; sequencer is past IDLE
//   done             one-cycle result-valid pulse
//   result           low WIDTH bits of a*b+c
//   overflow         true a*b+c does not fit in WIDTH bits
// Modports: master = requester (decode / bench), slave = sequencer.
interface multplus_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_c;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;

  modport master (
    output start, op_a, op_b, op_c,
    input  stall, busy, done, result, overflow
  );

  modport slave (
    input  start, op_a, op_b, op_c,
    output stall, busy, done, result, overflow
  );
endinterface

// File: rtl/multplus_sequencer.sv
// rtl/multplus_sequencer.sv - iterative shift-add multiply-accumulate sequencer for MULTPLUS
//
// Purpose: computes result = op_a*op_b + op_c (unsigned) over WIDTH shift-add
//          iterations, then one add cycle, then a one-cycle done pulse.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; aborts any operation in flight
//   bus    multplus_sequencer_if.slave (start/operands in; stall/busy/done/result/overflow out)
module multplus_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multplus_sequencer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             nextState;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   resultReg;
  logic               overflowReg;
  logic               busyReg;
  logic               doneReg;
  logic [WIDTH:0]     sumVal;

  // Low product half plus addend; the extra bit is the add carry.
  assign sumVal = {1'b0, acc[WIDTH-1:0]} + {1'b0, addend};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.start) nextState = RUN;
      RUN:     if (count == CW'(WIDTH - 1)) nextState = ADD;
      ADD:     nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      mcand       <= '0;
      mplier      <= '0;
      addend      <= '0;
      acc         <= '0;
      resultReg   <= '0;
      overflowReg <= 1'b0;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
    end else begin
      // busy/done are registered from the next state so they line up with it.
      busyReg <= (nextState != IDLE);
      doneReg <= (nextState == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= {{WIDTH{1'b0}}, bus.op_a};
            mplier <= bus.op_b;
            addend <= bus.op_c;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          // Fixed WIDTH iterations even when the multiplier runs out of ones.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        ADD: begin
          resultReg   <= sumVal[WIDTH-1:0];
          overflowReg <= (|acc[2*WIDTH-1:WIDTH]) | sumVal[WIDTH];
        end
        default: ;
      endcase
    end
  end

  // Stall drops in DONE so the instruction retires with the fresh result.
  assign bus.stall    = ((state == IDLE) & bus.start) | (state == RUN) | (state == ADD);
  assign bus.busy     = busyReg;
  assign bus.done     = doneReg;
  assign bus.result   = resultReg;
  assign bus.overflow = overflowReg;
endmodule
